// File: rtl/seq_detect_prog_if.sv
// Bus bundle for the programmable serial pattern detector.
// The master side drives configuration and the serial stream and receives
// the match pulse and match counter. The slave side is the detector.
interface seq_detect_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Configuration
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;

  // Serial stream and counter control
  logic               in_valid;
  logic               din;
  logic               cnt_clear;

  // Results
  logic               match;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output in_valid, din, cnt_clear,
    input  match, match_count
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  in_valid, din, cnt_clear,
    output match, match_count
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector (Moore, registered output).
// A MAX_LEN-bit history register collects qualified serial bits. A hit is
// declared when at least len bits have arrived since the last restart point
// and the newest len bits equal the low len bits of the loaded pattern.
// The pattern is written MSB-first: bit len-1 is the first bit received.
// In non-overlapping mode the fill counter restarts after each hit, so the
// next hit needs len fresh bits. A saturating counter tallies hits.
// len = 0 disables detection.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_detect_if.slave bus_io
);

  localparam int               LEN_W    = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Mask selecting the low len bits of a MAX_LEN-wide word.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Configuration registers
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;

  // Stream progress registers
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  // Output registers
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Combinational helpers
  logic [LEN_W-1:0]   len_clamp_s;
  logic [MAX_LEN-1:0] window_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               fill_ok_s;
  logic               pat_eq_s;
  logic               hit_s;

  // Clamp an over-long programmed length down to MAX_LEN.
  always_comb begin
    len_clamp_s = bus_io.cfg_len;
    if (bus_io.cfg_len > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = bus_io.cfg_len;
    end
  end

  // Hit detection on the bit presented this cycle; a config load swallows it.
  always_comb begin
    window_s  = {hist_q[MAX_LEN-2:0], bus_io.din};
    mask_s    = len_mask(len_q);
    fill_ok_s = ({1'b0, fill_q} + {LEN_ZERO, 1'b1}) >= {1'b0, len_q};
    pat_eq_s  = ((window_s ^ pat_q) & mask_s) == {MAX_LEN{1'b0}};
    hit_s     = bus_io.in_valid & ~bus_io.cfg_load & (len_q != LEN_ZERO)
                & fill_ok_s & pat_eq_s;
  end

  // Next-state for configuration, history, fill and match pulse.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (bus_io.cfg_load) begin
      pat_d   = bus_io.cfg_pattern;
      len_d   = len_clamp_s;
      ovl_d   = bus_io.cfg_overlap;
      hist_d  = {MAX_LEN{1'b0}};
      fill_d  = LEN_ZERO;
      match_d = 1'b0;
    end else if (bus_io.in_valid) begin
      hist_d  = window_s;
      match_d = hit_s;
      if (hit_s && !ovl_q) begin
        // Non-overlapping: restart so the next hit needs len fresh bits.
        fill_d = LEN_ZERO;
      end else if (fill_q < LEN_MAX) begin
        fill_d = fill_q + LEN_ONE;
      end else begin
        fill_d = fill_q;
      end
    end else begin
      // Gaps in in_valid leave the stream intact.
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
    end
  end

  // Saturating hit counter; a clear wins over a coincident hit.
  always_comb begin
    cnt_d = cnt_q;
    if (bus_io.cnt_clear) begin
      cnt_d = CNT_ZERO;
    end else if (hit_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous reset; all progress is dropped on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q   <= {MAX_LEN{1'b0}};
      len_q   <= LEN_ZERO;
      ovl_q   <= 1'b0;
      hist_q  <= {MAX_LEN{1'b0}};
      fill_q  <= LEN_ZERO;
      match_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.match       = match_q;
  assign bus_io.match_count = cnt_q;

endmodule
